decode_uop_sequencer: RTL and testbench
=======================================

# decode_uop_sequencer

Parametrised micro-op sequencer for decode stage 2. It selects the control-store address each cycle: the decoder entry address for the first micro-op of an instruction, or a registered next-micro-address for the following ones. It stalls the front end while a multi-micro-op sequence is in flight and aborts the sequence on interrupt or REPNE termination. An optional length guard forces exit from runaway sequences.

## Interface
Parameters:
- UADDR_W, 8: control-store address width.
- MAX_UOPS, 16: maximum micro-ops per instruction; must be ≥2 and a power of two.
- CNT_W, $clog2(MAX_UOPS): micro-op index width (derived; do not override).

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- d2_v  in  1  valid instruction in D2.
- d2_stall  in  1  downstream stall; freezes all sequencer state.
- decode_address  in  UADDR_W  entry address from decode.
- opcode_size  in  1  opcode-size bit from decode (1 = two-byte opcode).
- cs_uop_stall  in  1  control-store word flags that more micro-ops follow.
- cs_next_uaddr  in  UADDR_W  control-store next micro-address.
- int_exist  in  1  pending interrupt; aborts the sequence.
- repne_terminate  in  1  WB REPNE terminate-all; aborts the sequence.
- cs_addr  out  UADDR_W  address driven to the control store.
- cs_op_size  out  1  opcode-size bit to the control store.
- in_uop_seq  out  1  state is SEQ (a non-first micro-op is being issued).
- uop_stall_out  out  1  holds fetch/D1 so that D2 keeps the instruction.
- uop_index  out  CNT_W  index of the current micro-op (0 = first).
- uop_first  out  1  d2_v & state IDLE.
- uop_last  out  1  valid micro-op that ends the sequence.
- uop_overflow  out  1  one-cycle pulse when the length guard fires.

## Operation
- abort = int_exist | repne_terminate.
- more = d2_v & cs_uop_stall & ~abort & ~guard, where guard = (uop_index == MAX_UOPS-1) when the guard is compiled in, else 0.
- advance = more & ~d2_stall.
- States:
  - IDLE: cs_addr = decode_address; cs_op_size = opcode_size.
  - SEQ: cs_addr = next_uaddr_q; cs_op_size = 0.
- Transitions:
  - IDLE→SEQ on advance.
  - SEQ→SEQ on advance.
  - SEQ→IDLE when ~d2_stall & ~more. This covers the last micro-op, abort, guard, and d2_v low.
  - d2_stall=1 holds state, next_uaddr_q and uop_index, regardless of abort.
- On advance: next_uaddr_q ← cs_next_uaddr; uop_index ← uop_index+1.
- On return to IDLE: uop_index ← 0.
- uop_stall_out = more.
- uop_last = d2_v & ~more.
- uop_overflow = d2_v & cs_uop_stall & ~abort & guard & ~d2_stall.
- Abort has priority over the guard; an aborted sequence never raises uop_overflow.
- Address arithmetic: none. cs_next_uaddr is taken verbatim, and wraps are the control store's responsibility.

## Timing
- Registered state: state, next_uaddr_q, uop_index. All other outputs are combinational from state and the current inputs.
- The control-store lookup is combinational in the same cycle: cs_addr → cs_uop_stall/cs_next_uaddr → uop_stall_out within one cycle.
- An N-micro-op instruction occupies D2 for exactly N unstalled cycles. Each d2_stall cycle adds one cycle.
- Abort takes effect in the same cycle: uop_stall_out drops immediately, and the state is IDLE after the next unstalled edge.
- Reset values: state IDLE, next_uaddr_q 0, uop_index 0.
- Outputs during reset: in_uop_seq 0, uop_index 0, uop_overflow 0, cs_addr = decode_address. uop_stall_out, uop_first and uop_last follow the inputs combinationally.
- Reset asserted mid-sequence: next cycle is IDLE with index 0. No partial-sequence state survives.

## Configuration
- UOP_SEQ_LEN_GUARD_EN defined:
  - guard active.
  - A sequence still requesting more micro-ops at index MAX_UOPS-1 ends there, with uop_last=1 and a uop_overflow pulse.
- Not defined:
  - guard = 0 and uop_overflow is tied 0.
  - uop_index wraps modulo MAX_UOPS, and the sequence continues until cs_uop_stall=0.

## Test plan
- Single micro-op: d2_v=1, decode_address=8'h3A, cs_uop_stall=0 → cs_addr=3A, uop_first=uop_last=1, uop_stall_out=0, state stays IDLE.
- Three micro-ops: entry 8'h10 with next addresses 8'h41 then 8'h42, the last word having cs_uop_stall=0 → cs_addr 10,41,42 on consecutive cycles; uop_index 0,1,2; uop_stall_out 1,1,0; cs_op_size 1 then 0,0 (opcode_size=1 at entry).
- Stall hold: d2_stall=1 for 2 cycles at index 1 → cs_addr stays 41 and uop_index stays 1 for those cycles, then the sequence resumes to 42.
- Abort: int_exist=1 at index 1 (no stall) → uop_stall_out=0 and uop_last=1 the same cycle; next cycle IDLE with cs_addr=decode_address, uop_overflow=0.
- Guard (macro defined, MAX_UOPS=4): cs_uop_stall held 1 → index 0..3, then uop_overflow pulses at index 3, then IDLE. Without the macro, the index wraps 3→0 with no pulse.
- Reset mid-sequence: assert reset at index 2 → in_uop_seq=0 and uop_index=0 asynchronously, and the first cycle after release is IDLE.

Source files
------------

// File: rtl/decode_uop_sequencer_if.sv
// ----------------------------------------------------------------------------
// decode_uop_sequencer_if
// Groups the decode-stage-2 micro-op sequencer signals into one bundle.
//
// Parameters:
//   UADDR_W  - control-store address width
//   MAX_UOPS - maximum micro-ops per instruction (power of two, >= 2)
//   CNT_W    - micro-op index width, derived from MAX_UOPS (do not override)
//
// Signals (direction as seen by the sequencer, modport slave):
//   d2_v, d2_stall, decode_address, opcode_size  - from decode / pipeline
//   cs_uop_stall, cs_next_uaddr                  - from the control store
//   int_exist, repne_terminate                   - sequence abort requests
//   cs_addr, cs_op_size                          - to the control store
//   in_uop_seq, uop_stall_out, uop_index,
//   uop_first, uop_last, uop_overflow            - sequencer status
//
// Modports:
//   slave  - the sequencer itself
//   master - the environment (decode, control store, pipeline control)
// ----------------------------------------------------------------------------
interface decode_uop_sequencer_if #(
   parameter int UADDR_W  = 8,
   parameter int MAX_UOPS = 16,
   parameter int CNT_W    = $clog2(MAX_UOPS)
);
   logic               d2_v;
   logic               d2_stall;
   logic [UADDR_W-1:0] decode_address;
   logic               opcode_size;
   logic               cs_uop_stall;
   logic [UADDR_W-1:0] cs_next_uaddr;
   logic               int_exist;
   logic               repne_terminate;
   logic [UADDR_W-1:0] cs_addr;
   logic               cs_op_size;
   logic               in_uop_seq;
   logic               uop_stall_out;
   logic [CNT_W-1:0]   uop_index;
   logic               uop_first;
   logic               uop_last;
   logic               uop_overflow;

   modport slave (
      input  d2_v, d2_stall, decode_address, opcode_size,
             cs_uop_stall, cs_next_uaddr, int_exist, repne_terminate,
      output cs_addr, cs_op_size, in_uop_seq, uop_stall_out,
             uop_index, uop_first, uop_last, uop_overflow
   );

   modport master (
      output d2_v, d2_stall, decode_address, opcode_size,
             cs_uop_stall, cs_next_uaddr, int_exist, repne_terminate,
      input  cs_addr, cs_op_size, in_uop_seq, uop_stall_out,
             uop_index, uop_first, uop_last, uop_overflow
   );
endinterface

// File: rtl/decode_uop_sequencer.sv
// ----------------------------------------------------------------------------
// decode_uop_sequencer
// Micro-op sequencer for decode stage 2. Each cycle it picks the control-store
// address: the decoder entry address for the first micro-op of an instruction,
// or the registered next-micro-address for the following ones. While more
// micro-ops are pending it stalls fetch/D1 so D2 keeps the instruction. An
// interrupt or a REPNE terminate-all aborts the sequence in the same cycle.
//
// Optional feature: define UOP_SEQ_LEN_GUARD_EN to force a runaway sequence to
// end at index MAX_UOPS-1 with a one-cycle uop_overflow pulse. Without it the
// index wraps modulo MAX_UOPS and uop_overflow is tied low.
//
// Ports:
//   clk   - clock, all state on the rising edge
//   reset - asynchronous, active-high reset
//   sq    - decode_uop_sequencer_if.slave bundle (see the interface file)
//
// Parameters UADDR_W / MAX_UOPS must match those of the connected interface.
// ----------------------------------------------------------------------------
module decode_uop_sequencer #(
   parameter int UADDR_W  = 8,
   parameter int MAX_UOPS = 16
) (
   input logic                   clk,
   input logic                   reset,
   decode_uop_sequencer_if.slave sq
);
   localparam int CNT_W = $clog2(MAX_UOPS);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_SEQ  = 1'b1
   } state_t;

   state_t             state_r;
   state_t             state_nxt_s;
   logic [UADDR_W-1:0] next_uaddr_r;
   logic [UADDR_W-1:0] next_uaddr_nxt_s;
   logic [CNT_W-1:0]   uop_index_r;
   logic [CNT_W-1:0]   uop_index_nxt_s;

   logic               abort_s;
   logic               guard_s;
   logic               more_s;
   logic               overflow_s;
   logic [UADDR_W-1:0] cs_addr_s;
   logic               cs_op_size_s;

   // Sequence-control terms: abort beats the length guard because guard only
   // matters when more would otherwise be asserted.
   always_comb begin
      abort_s = sq.int_exist | sq.repne_terminate;
`ifdef UOP_SEQ_LEN_GUARD_EN
      guard_s    = (uop_index_r == CNT_W'(MAX_UOPS - 1));
      overflow_s = sq.d2_v & sq.cs_uop_stall & ~abort_s & guard_s & ~sq.d2_stall;
`else
      guard_s    = 1'b0;
      overflow_s = 1'b0;
`endif
      more_s = sq.d2_v & sq.cs_uop_stall & ~abort_s & ~guard_s;
   end

   // Next-state logic: d2_stall freezes everything, even an abort.
   always_comb begin
      state_nxt_s      = state_r;
      next_uaddr_nxt_s = next_uaddr_r;
      uop_index_nxt_s  = uop_index_r;
      if (!sq.d2_stall) begin
         if (more_s) begin
            // Next address is taken verbatim; wrap handling lives in the store.
            state_nxt_s      = ST_SEQ;
            next_uaddr_nxt_s = sq.cs_next_uaddr;
            uop_index_nxt_s  = uop_index_r + CNT_W'(1'b1);
         end else begin
            state_nxt_s      = ST_IDLE;
            next_uaddr_nxt_s = next_uaddr_r;
            uop_index_nxt_s  = {CNT_W{1'b0}};
         end
      end else begin
         state_nxt_s      = state_r;
         next_uaddr_nxt_s = next_uaddr_r;
         uop_index_nxt_s  = uop_index_r;
      end
   end

   // Sequencer state registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r      <= ST_IDLE;
         next_uaddr_r <= {UADDR_W{1'b0}};
         uop_index_r  <= {CNT_W{1'b0}};
      end else begin
         state_r      <= state_nxt_s;
         next_uaddr_r <= next_uaddr_nxt_s;
         uop_index_r  <= uop_index_nxt_s;
      end
   end

   // Control-store address mux: entry address in IDLE, registered link in SEQ.
   always_comb begin
      cs_addr_s    = sq.decode_address;
      cs_op_size_s = sq.opcode_size;
      case (state_r)
         ST_IDLE: begin
            cs_addr_s    = sq.decode_address;
            cs_op_size_s = sq.opcode_size;
         end
         ST_SEQ: begin
            cs_addr_s    = next_uaddr_r;
            cs_op_size_s = 1'b0;
         end
         default: begin
            cs_addr_s    = sq.decode_address;
            cs_op_size_s = sq.opcode_size;
         end
      endcase
   end

   assign sq.cs_addr       = cs_addr_s;
   assign sq.cs_op_size    = cs_op_size_s;
   assign sq.in_uop_seq    = (state_r == ST_SEQ);
   assign sq.uop_stall_out = more_s;
   assign sq.uop_index     = uop_index_r;
   assign sq.uop_first     = sq.d2_v & (state_r == ST_IDLE);
   assign sq.uop_last      = sq.d2_v & ~more_s;
   assign sq.uop_overflow  = overflow_s;

endmodule

// File: tb/tb_decode_uop_sequencer.sv
// ----------------------------------------------------------------------------
// tb_decode_uop_sequencer
// Directed bench for decode_uop_sequencer (MAX_UOPS = 4). An instruction-level
// model tracks how many micro-ops of the current instruction have issued and
// the link address to use next; a negedge process compares every output to
// it. Directed steps add literal expectations that pin the model.
// Builds with or without UOP_SEQ_LEN_GUARD_EN.
// ----------------------------------------------------------------------------
module tb_decode_uop_sequencer;
   localparam int UADDR_W = 8;
   localparam int MAXU    = 4;
`ifdef UOP_SEQ_LEN_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   decode_uop_sequencer_if #(.UADDR_W(UADDR_W), .MAX_UOPS(MAXU)) sq_if ();

   decode_uop_sequencer #(.UADDR_W(UADDR_W), .MAX_UOPS(MAXU)) dut (
      .clk   (clk),
      .reset (reset),
      .sq    (sq_if)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Instruction-level model: issued = micro-ops already issued for the
   // instruction in D2 (0 means the next one is the entry micro-op).
   int         m_issued = 0;
   logic [7:0] m_link   = 8'h00;

   function automatic bit m_abort();
      return sq_if.int_exist || sq_if.repne_terminate;
   endfunction

   function automatic bit m_at_limit();
      return GUARD && (m_issued == MAXU - 1);
   endfunction

   function automatic bit m_wants_more();
      return sq_if.d2_v && sq_if.cs_uop_stall && !m_abort() && !m_at_limit();
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_issued <= 0;
         m_link   <= 8'h00;
      end else if (!sq_if.d2_stall) begin
         if (m_wants_more()) begin
            m_issued <= (m_issued + 1) % MAXU;
            m_link   <= sq_if.cs_next_uaddr;
         end else begin
            m_issued <= 0;
         end
      end
   end

   // The model is "in a sequence" once at least one micro-op went out. In the
   // unguarded build a wrapped index reads 0 while still in sequence, so track
   // that separately.
   bit m_inseq = 1'b0;
   always @(posedge clk or posedge reset) begin
      if (reset) m_inseq <= 1'b0;
      else if (!sq_if.d2_stall) m_inseq <= m_wants_more();
   end

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      chk("cs_addr",    32'(sq_if.cs_addr),    32'(m_inseq ? m_link : sq_if.decode_address));
      chk("cs_op_size", 32'(sq_if.cs_op_size), 32'(m_inseq ? 1'b0 : sq_if.opcode_size));
      chk("in_uop_seq", 32'(sq_if.in_uop_seq), 32'(m_inseq));
      chk("stall_out",  32'(sq_if.uop_stall_out), 32'(m_wants_more()));
      chk("uop_index",  32'(sq_if.uop_index),  32'(m_issued));
      chk("uop_first",  32'(sq_if.uop_first),  32'(sq_if.d2_v && !m_inseq));
      chk("uop_last",   32'(sq_if.uop_last),   32'(sq_if.d2_v && !m_wants_more()));
      chk("overflow",   32'(sq_if.uop_overflow),
          32'(sq_if.d2_v && sq_if.cs_uop_stall && !m_abort() && m_at_limit() && !sq_if.d2_stall));
   end

   task automatic drive(input logic v, input logic st, input logic [7:0] da, input logic os,
                        input logic cst, input logic [7:0] cn, input logic ix, input logic rp);
      sq_if.d2_v            = v;
      sq_if.d2_stall        = st;
      sq_if.decode_address  = da;
      sq_if.opcode_size     = os;
      sq_if.cs_uop_stall    = cst;
      sq_if.cs_next_uaddr   = cn;
      sq_if.int_exist       = ix;
      sq_if.repne_terminate = rp;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      drive(1'b0, 1'b0, 8'h55, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      @(negedge clk);
      chk("rst_in_seq",  32'(sq_if.in_uop_seq),   32'd0);
      chk("rst_index",   32'(sq_if.uop_index),    32'd0);
      chk("rst_cs_addr", 32'(sq_if.cs_addr),      32'h55);
      chk("rst_ovf",     32'(sq_if.uop_overflow), 32'd0);
      tick();
      reset = 1'b0;

      // Single micro-op instruction.
      drive(1'b1, 1'b0, 8'h3A, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      @(negedge clk);
      chk("single_addr",  32'(sq_if.cs_addr),       32'h3A);
      chk("single_first", 32'(sq_if.uop_first),     32'd1);
      chk("single_last",  32'(sq_if.uop_last),      32'd1);
      chk("single_stall", 32'(sq_if.uop_stall_out), 32'd0);
      tick();
      drive(1'b0, 1'b0, 8'h3A, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      @(negedge clk);
      chk("single_idle", 32'(sq_if.in_uop_seq), 32'd0);
      tick();

      // Three micro-ops: 10 -> 41 -> 42.
      drive(1'b1, 1'b0, 8'h10, 1'b1, 1'b1, 8'h41, 1'b0, 1'b0);
      @(negedge clk);
      chk("three_a_addr", 32'(sq_if.cs_addr),       32'h10);
      chk("three_a_osz",  32'(sq_if.cs_op_size),    32'd1);
      chk("three_a_stl",  32'(sq_if.uop_stall_out), 32'd1);
      tick();
      drive(1'b1, 1'b0, 8'h10, 1'b1, 1'b1, 8'h42, 1'b0, 1'b0);
      @(negedge clk);
      chk("three_b_addr", 32'(sq_if.cs_addr),    32'h41);
      chk("three_b_idx",  32'(sq_if.uop_index),  32'd1);
      chk("three_b_osz",  32'(sq_if.cs_op_size), 32'd0);
      tick();
      drive(1'b1, 1'b0, 8'h10, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      @(negedge clk);
      chk("three_c_addr", 32'(sq_if.cs_addr),       32'h42);
      chk("three_c_idx",  32'(sq_if.uop_index),     32'd2);
      chk("three_c_stl",  32'(sq_if.uop_stall_out), 32'd0);
      chk("three_c_last", 32'(sq_if.uop_last),      32'd1);
      tick();
      drive(1'b0, 1'b0, 8'h10, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      @(negedge clk);
      chk("three_end_idx", 32'(sq_if.uop_index), 32'd0);
      tick();

      // Stall hold for two cycles at index 1.
      drive(1'b1, 1'b0, 8'h10, 1'b1, 1'b1, 8'h41, 1'b0, 1'b0);
      tick();
      for (int k = 0; k < 2; k++) begin
         drive(1'b1, 1'b1, 8'h10, 1'b1, 1'b1, 8'h42, 1'b0, 1'b0);
         @(negedge clk);
         chk("hold_addr", 32'(sq_if.cs_addr),   32'h41);
         chk("hold_idx",  32'(sq_if.uop_index), 32'd1);
         tick();
      end
      drive(1'b1, 1'b0, 8'h10, 1'b1, 1'b1, 8'h42, 1'b0, 1'b0);
      tick();
      drive(1'b1, 1'b0, 8'h10, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      @(negedge clk);
      chk("resume_addr", 32'(sq_if.cs_addr),   32'h42);
      chk("resume_idx",  32'(sq_if.uop_index), 32'd2);
      tick();

      // Abort by interrupt at index 1.
      drive(1'b1, 1'b0, 8'h10, 1'b1, 1'b1, 8'h41, 1'b0, 1'b0);
      tick();
      drive(1'b1, 1'b0, 8'h10, 1'b1, 1'b1, 8'h42, 1'b1, 1'b0);
      @(negedge clk);
      chk("abort_stall", 32'(sq_if.uop_stall_out), 32'd0);
      chk("abort_last",  32'(sq_if.uop_last),      32'd1);
      tick();
      drive(1'b1, 1'b0, 8'h77, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      @(negedge clk);
      chk("abort_next_addr", 32'(sq_if.cs_addr),      32'h77);
      chk("abort_next_seq",  32'(sq_if.in_uop_seq),   32'd0);
      chk("abort_next_ovf",  32'(sq_if.uop_overflow), 32'd0);
      tick();

      // REPNE abort under d2_stall holds state.
      drive(1'b1, 1'b0, 8'h10, 1'b1, 1'b1, 8'h41, 1'b0, 1'b0);
      tick();
      drive(1'b1, 1'b1, 8'h10, 1'b1, 1'b1, 8'h42, 1'b0, 1'b1);
      @(negedge clk);
      chk("rep_stall_out", 32'(sq_if.uop_stall_out), 32'd0);
      tick();
      drive(1'b1, 1'b0, 8'h10, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      @(negedge clk);
      chk("rep_hold_seq", 32'(sq_if.in_uop_seq), 32'd1);
      chk("rep_hold_idx", 32'(sq_if.uop_index),  32'd1);
      tick();

      // Runaway sequence: guard fires at index 3, or index wraps.
      for (int i = 0; i < MAXU; i++) begin
         drive(1'b1, 1'b0, 8'h60, 1'b0, 1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
         @(negedge clk);
         chk("run_idx",   32'(sq_if.uop_index),     32'(i));
         chk("run_ovf",   32'(sq_if.uop_overflow),  32'((i == MAXU - 1) && GUARD));
         chk("run_stall", 32'(sq_if.uop_stall_out), 32'(!((i == MAXU - 1) && GUARD)));
         tick();
      end
      drive(1'b1, 1'b0, 8'h60, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      @(negedge clk);
      chk("run_after_idx", 32'(sq_if.uop_index),  32'd0);
      chk("run_after_seq", 32'(sq_if.in_uop_seq), 32'(!GUARD));
      tick();
      drive(1'b0, 1'b0, 8'h60, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      tick();

      // Reset asserted at index 2.
      drive(1'b1, 1'b0, 8'h10, 1'b1, 1'b1, 8'h41, 1'b0, 1'b0);
      tick();
      drive(1'b1, 1'b0, 8'h10, 1'b1, 1'b1, 8'h42, 1'b0, 1'b0);
      tick();
      drive(1'b1, 1'b0, 8'h10, 1'b1, 1'b1, 8'h43, 1'b0, 1'b0);
      @(negedge clk);
      chk("pre_rst_idx", 32'(sq_if.uop_index), 32'd2);
      #2;
      reset = 1'b1;
      #1;
      chk("async_rst_seq", 32'(sq_if.in_uop_seq), 32'd0);
      chk("async_rst_idx", 32'(sq_if.uop_index),  32'd0);
      tick();
      reset = 1'b0;
      drive(1'b1, 1'b0, 8'h20, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      @(negedge clk);
      chk("post_rst_addr",  32'(sq_if.cs_addr),    32'h20);
      chk("post_rst_first", 32'(sq_if.uop_first),  32'd1);
      chk("post_rst_seq",   32'(sq_if.in_uop_seq), 32'd0);
      tick();
      drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      @(negedge clk);
      #1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
